nn_layer_sequencer: RTL and testbench
=====================================

// Module: nn_layer_sequencer
// PURPOSE
//  Primary control FSM for the NN accelerator. Sequences the auxiliary datapath controller through its four tasks:
//  init registers, load layer data, process layer, write output. Iterates over every layer and tracks the current stage.
//  Sits between the ARM-side start/status interface and the aux FSM's begin_*/done handshake pairs.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max cycles to wait for any aux done pulse before entering ERR
//  STAGE_W         8     width of stage / layer-count fields
// PORTS
//  clk                        in   1        system clock, rising edge
//  reset                      in   1        asynchronous, active-high reset
//  start                      in   1        run request from CPU; level or pulse, sampled in IDLE/DONE/ERR only
//  totalLayerNumber           in   STAGE_W  layer count from aux, valid once registers_initialized has pulsed
//  registers_initialized      in   1        aux 1-cycle done pulse for init
//  data_loaded                in   1        aux 1-cycle done pulse for load
//  data_processed             in   1        aux 1-cycle done pulse for process
//  output_written             in   1        aux 1-cycle done pulse for write
//  begin_initialize_registers out  1        1-cycle request to aux
//  begin_load_data            out  1        1-cycle request to aux
//  begin_process_data         out  1        1-cycle request to aux
//  begin_write_output         out  1        1-cycle request to aux
//  stage                      out  STAGE_W  current layer index; 1 = first weight layer
//  busy                       out  1        high from start acceptance until DONE/ERR
//  done                       out  1        sticky run-complete flag
//  error                      out  1        sticky fault flag: timeout or bad layer count
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0; stage=0. Watchdog=0.
//  All outputs are registered. Each begin_* is high for exactly one cycle, on the cycle the FSM enters the matching WAIT_* state.
//  States and transitions:
//   IDLE/DONE/ERR: if start, go to INIT. On that edge: done=0, error=0, busy=1, stage=0.
//   INIT: pulse begin_initialize_registers, go to W_INIT.
//   W_INIT: on registers_initialized, latch totalLayerNumber into nl.
//    If nl<2, go to ERR. Otherwise stage=1 and go to GAP_L.
//   GAP_L: one idle cycle so aux is back in its idle state, then go to LOAD.
//   LOAD: pulse begin_load_data, go to W_LOAD.
//   W_LOAD: on data_loaded, go to GAP_P.
//   GAP_P: one idle cycle, then go to PROC.
//   PROC: pulse begin_process_data, go to W_PROC.
//   W_PROC: on data_processed, go to NEXT.
//   NEXT: if stage == nl-1, go to GAP_W. Otherwise stage=stage+1 and go to GAP_L.
//   GAP_W: one idle cycle, then go to WRITE.
//   WRITE: pulse begin_write_output, go to W_WRITE.
//   W_WRITE: on output_written, go to DONE with busy=0, done=1.
//  stage is stable in every cycle from LOAD through W_PROC. It changes only in NEXT or W_INIT.
//  Watchdog: clears on entry to each W_* state and counts every cycle spent in a W_* state.
//   On reaching TIMEOUT_CYCLES-1 with no done pulse, go to ERR: busy=0, error=1, stage held.
//  Done pulses that arrive while not in the matching W_* state are ignored.
//  start while busy is ignored.
//  A done pulse and a timeout in the same cycle: the done pulse wins.
//  nl arithmetic is unsigned STAGE_W bits. nl=255 is legal; stage never wraps, because the nl<2 check bounds nl-1.
//  Reset mid-run returns immediately to IDLE with reset values. The aux FSM is reset by the same reset.
// STRUCTURE
//  Package nn_seq_pkg: seq_state_t enum (IDLE, INIT, W_INIT, GAP_L, LOAD, W_LOAD, GAP_P, PROC, W_PROC, NEXT, GAP_W, WRITE,
//   W_WRITE, DONE, ERR) and constant STAGE_FIRST=1.
//  Sub-module nn_seq_watchdog: clear, enable, expired output; parameter TIMEOUT_CYCLES.
//  Top is a two-process FSM with a registered output block.
// TESTING
//  1. nl=3; aux model replies 5 cycles after each begin.
//     -> order: init, load(1), proc(1), load(2), proc(2), write. done=1, busy=0, each begin 1 cycle wide.
//  2. nl=2 -> exactly one load/proc pair at stage=1, then write. Final stage=1.
//  3. nl=1 -> ERR after W_INIT, error=1, no begin_load_data ever.
//     A following start with nl=3 clears error and completes.
//  4. TIMEOUT_CYCLES=16; aux never asserts data_processed -> error=1 exactly 16 cycles after begin_process_data.
//  5. Assert start and stray data_loaded during W_PROC -> both ignored, sequence unchanged.
//  6. Assert reset during W_LOAD at stage=2 -> all outputs 0, IDLE.
//     A new start reruns from INIT with stage 1.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared state encoding and constants for the NN layer sequencer.
package nn_seq_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    W_INIT  = 4'd2,
    GAP_L   = 4'd3,
    LOAD    = 4'd4,
    W_LOAD  = 4'd5,
    GAP_P   = 4'd6,
    PROC    = 4'd7,
    W_PROC  = 4'd8,
    NEXT    = 4'd9,
    GAP_W   = 4'd10,
    WRITE   = 4'd11,
    W_WRITE = 4'd12,
    DONE    = 4'd13,
    ERR     = 4'd14
  } seq_state_t;

  localparam int unsigned STAGE_FIRST = 1;

  function automatic logic is_wait(seq_state_t s);
    return (s == W_INIT) || (s == W_LOAD) || (s == W_PROC) || (s == W_WRITE);
  endfunction

endpackage

// File: rtl/nn_seq_watchdog.sv
// Cycle watchdog for the aux done handshakes; expires after TIMEOUT_CYCLES-1 enabled cycles.
module nn_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Primary NN accelerator control FSM: drives the aux controller through init, per-layer load/process, and write.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STAGE_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [STAGE_W-1:0] totalLayerNumber,
  input  logic               registers_initialized,
  input  logic               data_loaded,
  input  logic               data_processed,
  input  logic               output_written,
  output logic               begin_initialize_registers,
  output logic               begin_load_data,
  output logic               begin_process_data,
  output logic               begin_write_output,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               done,
  output logic               error
);

  // Handshake with aux: each begin_* is a single-cycle request raised on entry to the
  // matching W_* state; the reply is a single-cycle done pulse that only counts while
  // the FSM sits in that W_* state, otherwise it is dropped.

  seq_state_t         state, next_state;
  logic [STAGE_W-1:0] nl;
  logic [STAGE_W-1:0] last_stage;
  logic               in_wait;
  logic               wd_expired;

  assign in_wait    = is_wait(state);
  assign last_stage = nl - STAGE_W'(1);

  nn_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = INIT;
      INIT:    next_state = W_INIT;
      W_INIT: begin
        if (registers_initialized)
          next_state = (totalLayerNumber < STAGE_W'(2)) ? ERR : GAP_L;
        else if (wd_expired)
          next_state = ERR;
      end
      GAP_L:   next_state = LOAD;
      LOAD:    next_state = W_LOAD;
      W_LOAD: begin
        if (data_loaded)     next_state = GAP_P;
        else if (wd_expired) next_state = ERR;
      end
      GAP_P:   next_state = PROC;
      PROC:    next_state = W_PROC;
      W_PROC: begin
        if (data_processed)  next_state = NEXT;
        else if (wd_expired) next_state = ERR;
      end
      NEXT:    next_state = (stage == last_stage) ? GAP_W : GAP_L;
      GAP_W:   next_state = WRITE;
      WRITE:   next_state = W_WRITE;
      W_WRITE: begin
        if (output_written)  next_state = DONE;
        else if (wd_expired) next_state = ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      begin_initialize_registers <= 1'b0;
      begin_load_data            <= 1'b0;
      begin_process_data         <= 1'b0;
      begin_write_output         <= 1'b0;
      stage                      <= '0;
      nl                         <= '0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      error                      <= 1'b0;
    end else begin
      begin_initialize_registers <= (next_state == W_INIT)  && (state != W_INIT);
      begin_load_data            <= (next_state == W_LOAD)  && (state != W_LOAD);
      begin_process_data         <= (next_state == W_PROC)  && (state != W_PROC);
      begin_write_output         <= (next_state == W_WRITE) && (state != W_WRITE);

      if ((next_state == INIT) && (state != INIT)) begin
        busy  <= 1'b1;
        done  <= 1'b0;
        error <= 1'b0;
        stage <= '0;
      end

      if ((state == W_INIT) && registers_initialized) begin
        nl <= totalLayerNumber;
        if (totalLayerNumber >= STAGE_W'(2)) stage <= STAGE_W'(STAGE_FIRST);
      end

      if ((state == NEXT) && (next_state == GAP_L)) stage <= stage + STAGE_W'(1);

      // Covers both the bad layer count and a watchdog expiry; stage is left as-is.
      if ((next_state == ERR) && (state != ERR)) begin
        busy  <= 1'b0;
        error <= 1'b1;
      end

      if ((next_state == DONE) && (state != DONE)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: table of jobs served by a simple aux responder, plus reset-abort sequence.
module tb_nn_layer_sequencer;

  localparam int TO = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [SW-1:0] total_layers;
  logic          registers_initialized;
  logic          data_loaded;
  logic          data_processed;
  logic          output_written;
  logic          begin_initialize_registers;
  logic          begin_load_data;
  logic          begin_process_data;
  logic          begin_write_output;
  logic [SW-1:0] stage;
  logic          busy;
  logic          done;
  logic          error;

  nn_layer_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .STAGE_W       (SW)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .totalLayerNumber          (total_layers),
    .registers_initialized     (registers_initialized),
    .data_loaded               (data_loaded),
    .data_processed            (data_processed),
    .output_written            (output_written),
    .begin_initialize_registers(begin_initialize_registers),
    .begin_load_data           (begin_load_data),
    .begin_process_data        (begin_process_data),
    .begin_write_output        (begin_write_output),
    .stage                     (stage),
    .busy                      (busy),
    .done                      (done),
    .error                     (error)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] nl;
    int         dly;
    bit         hang;
    bit         stray;
    bit         exp_done;
    bit         exp_err;
    logic [7:0] exp_stage;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          tc;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic clear_aux();
    registers_initialized = 1'b0;
    data_loaded           = 1'b0;
    data_processed        = 1'b0;
    output_written        = 1'b0;
  endtask

  // expected op stream: {kind, stage}; kind 1=init 2=load 3=proc 4=write
  task automatic build_expected(input logic [7:0] nl, input bit hang);
    exp_q.delete();
    exp_q.push_back({8'd1, 8'd0});
    if (nl >= 8'd2) begin
      for (int s = 1; s < int'(nl); s++) begin
        exp_q.push_back({8'd2, 8'(s)});
        exp_q.push_back({8'd3, 8'(s)});
        if (hang) return;
      end
      exp_q.push_back({8'd4, nl - 8'd1});
    end
  endtask

  task automatic run_job(input logic [7:0] nl, input int dly, input bit hang, input bit stray,
                         input int abort_stage, output int to_cycles);
    int         cyc;
    int         pend_kind;
    int         pend_cnt;
    int         proc_cyc;
    logic [3:0] b;
    logic [3:0] prev_b;
    bit         fin;
    total_layers = nl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_err", error, 0);
    cyc = 0; pend_kind = 0; pend_cnt = 0; proc_cyc = -1; prev_b = '0; fin = 0; to_cycles = -1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      clear_aux();
      start = 1'b0;
      b = {begin_write_output, begin_process_data, begin_load_data, begin_initialize_registers};
      if (prev_b != 4'd0) check("begin_width", int'(b & prev_b), 0);
      prev_b = b;
      for (int k = 0; k < 4; k++) begin
        if (b[k]) begin
          if (exp_q.size() == 0) check("extra_op", k + 1, 0);
          else check("op_kind_stage", int'({8'(k + 1), stage}), int'(exp_q.pop_front()));
          pend_kind = k + 1;
          pend_cnt  = dly;
          if (k == 2) proc_cyc = cyc;
          if ((k == 1) && (abort_stage != 0) && (int'(stage) == abort_stage)) fin = 1;
        end
      end
      if ((b == 4'd0) && (pend_kind != 0)) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          case (pend_kind)
            1: registers_initialized = 1'b1;
            2: data_loaded           = 1'b1;
            3: if (!hang) data_processed = 1'b1;
            default: output_written  = 1'b1;
          endcase
          pend_kind = 0;
        end
      end
      if (stray && b[2]) begin
        start       = 1'b1;
        data_loaded = 1'b1;
      end
      if (done || error) fin = 1;
      if (cyc >= 3000) begin
        check("job_budget", cyc, 0);
        fin = 1;
      end
    end
    clear_aux();
    start = 1'b0;
    if (hang && error && (proc_cyc >= 0)) to_cycles = cyc - proc_cyc;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    total_layers = '0;
    clear_aux();
    repeat (3) @(negedge clk);
    check("rst_begin_init", begin_initialize_registers, 0);
    check("rst_begin_load", begin_load_data, 0);
    check("rst_begin_proc", begin_process_data, 0);
    check("rst_begin_write", begin_write_output, 0);
    check("rst_stage", stage, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    vecs[0] = '{8'd3, 5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[1] = '{8'd2, 5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[2] = '{8'd1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[3] = '{8'd3, 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[4] = '{8'd0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[5] = '{8'd4, 1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    vecs[6] = '{8'd3, 5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};

    for (int i = 0; i < 7; i++) begin
      build_expected(vecs[i].nl, vecs[i].hang);
      run_job(vecs[i].nl, vecs[i].dly, vecs[i].hang, vecs[i].stray, 0, tc);
      check("missing_ops", exp_q.size(), 0);
      check("final_done", done, int'(vecs[i].exp_done));
      check("final_error", error, int'(vecs[i].exp_err));
      check("final_busy", busy, 0);
      check("final_stage", stage, int'(vecs[i].exp_stage));
      if (vecs[i].hang) check("timeout_cycles", tc, TO);
      repeat (3) @(negedge clk);
      check("sticky_done", done, int'(vecs[i].exp_done));
      check("sticky_error", error, int'(vecs[i].exp_err));
    end

    // reset while waiting for data_loaded at stage 2
    build_expected(8'd3, 1'b0);
    run_job(8'd3, 5, 1'b0, 1'b0, 2, tc);
    check("abort_stage", stage, 2);
    check("abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_stage", stage, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_begin_load", begin_load_data, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    build_expected(8'd3, 1'b0);
    run_job(8'd3, 4, 1'b0, 1'b0, 0, tc);
    check("rerun_missing_ops", exp_q.size(), 0);
    check("rerun_done", done, 1);
    check("rerun_error", error, 0);
    check("rerun_stage", stage, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
